// File: rtl/dmem_arb_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, FSM states, port count.
package dmem_arb_pkg;

  localparam int NUM_PORTS = 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter (CPU LSU or loader/debug master).
interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);
  // Handshake: the master raises req with we/size/sext/addr/wdata and holds them
  // stable until gnt pulses; in the gnt cycle it may drop req or present the next
  // request. rvalid pulses exactly once per grant, carrying err and rdata.
  logic             req;
  logic             we;
  logic [1:0]       size;
  logic             sext;
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             gnt;
  logic             rvalid;
  logic             err;
  logic [WIDTH-1:0] rdata;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/dmem_arbiter_mem_lane_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and
// sign/zero extension, and alignment/size checking.
module mem_lane_align
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size,
  input  logic [1:0]       addr_lo,
  input  logic             sext,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata_rep,
  output logic [WIDTH-1:0] rdata_ext,
  output logic             misaligned
);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted    = rdata >> {addr_lo, 3'b000};
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = shifted;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {(WIDTH/8){wdata[7:0]}};
        rdata_ext = {{(WIDTH-8){sext & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {(WIDTH/16){wdata[15:0]}};
        rdata_ext  = {{(WIDTH-16){sext & shifted[15]}}, shifted[15:0]};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the synchronous-read data RAM.
// ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  dmem_arbiter_if.slave    p0,
  dmem_arbiter_if.slave    p1,
  output logic             mem_en,
  output logic             mem_we,
  output logic [3:0]       mem_be,
  output logic [WIDTH-3:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic             port_q, port_d;
  logic             we_q, we_d;
  logic [1:0]       size_q, size_d;
  logic             sext_q, sext_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  logic             any_req;
  logic             win;
  logic             issue, resp;
  logic             req_err;
  logic             misaligned;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata_rep;
  logic [WIDTH-1:0] rdata_ext;
  logic [WIDTH-1:0] rd_word;

  assign any_req = p0.req | p1.req;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  always_comb begin
    win    = (p0.req && p1.req) ? ~last_q : ~p0.req;
    last_d = last_q;
    if (state_q != ISSUE && any_req) last_d = win;
  end

  // Reset to port 1 so port 0 takes the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`else
  always_comb begin
    win = ~p0.req;
  end
`endif

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (any_req) begin
          state_d = ISSUE;
          port_d  = win;
          we_d    = win ? p1.we    : p0.we;
          size_d  = win ? p1.size  : p0.size;
          sext_d  = win ? p1.sext  : p0.sext;
          addr_d  = win ? p1.addr  : p0.addr;
          wdata_d = win ? p1.wdata : p0.wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  mem_lane_align #(.WIDTH(WIDTH)) u_align (
    .size       (size_q),
    .addr_lo    (addr_q[1:0]),
    .sext       (sext_q),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  // Out-of-range is any set bit above the implemented byte-address space.
  assign req_err = misaligned | (|addr_q[WIDTH-1:ADDR_WIDTH]);
  assign issue   = (state_q == ISSUE);
  assign resp    = (state_q == RESP);
  assign rd_word = (resp && !req_err && !we_q) ? rdata_ext : '0;

  assign p0.gnt    = issue & ~port_q;
  assign p1.gnt    = issue &  port_q;
  assign p0.rvalid = resp  & ~port_q;
  assign p1.rvalid = resp  &  port_q;
  assign p0.err    = resp  & ~port_q & req_err;
  assign p1.err    = resp  &  port_q & req_err;
  assign p0.rdata  = port_q ? '0 : rd_word;
  assign p1.rdata  = port_q ? rd_word : '0;

  assign mem_en    = issue & ~req_err;
  assign mem_we    = mem_en & we_q;
  assign mem_be    = mem_en ? be : 4'b0000;
  assign mem_addr  = mem_en ? addr_q[WIDTH-1:2] : '0;
  assign mem_wdata = (mem_en && we_q) ? wdata_rep : '0;

  assign dbg_state = state_q;

endmodule
